// File: rtl/twiddle_fetch_seq_if.sv
// Coefficient stream from twiddle_fetch_seq to the FFT butterfly datapath (valid/ready).
interface twiddle_fetch_seq_if #(
   parameter int DATA_W = 16
);
   logic              tw_valid;
   logic              tw_ready;
   logic [DATA_W-1:0] tw_data;
   logic [2:0]        tw_stage;
   logic [1:0]        tw_idx;
   logic              tw_last;

   modport master (output tw_valid, tw_data, tw_stage, tw_idx, tw_last, input tw_ready);
   modport slave  (input tw_valid, tw_data, tw_stage, tw_idx, tw_last, output tw_ready);
endinterface

// File: rtl/twiddle_fetch_seq.sv
// Walks the twiddle ROM (ROWS x 4, 1-cycle read) and streams tagged coefficients; first valid 2 cycles after start.
// tw_ready low stalls issue through a 2-entry skid FIFO credit; TWIDDLE_CONJ_EN selects saturating negation at push.

module twiddle_skid_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
)(
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_dat,
   input  logic                       pop,
   output logic [WIDTH-1:0]           head_dat,
   output logic [$clog2(DEPTH+1)-1:0] count
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;

   // DEPTH is a power of two, so the pointers wrap on their own.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_dat;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: ;
         endcase
      end
   end

   assign head_dat = mem[rd_ptr];
endmodule

module twiddle_fetch_seq #(
   parameter int ROWS       = 7,
   parameter int DATA_W     = 16,
   parameter int ADDR_W     = 5,
   parameter int FIFO_DEPTH = 2
)(
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   output logic                busy,
   output logic                done,
   output logic [ADDR_W-1:0]   rom_addr,
   input  logic [DATA_W-1:0]   rom_data,
   twiddle_fetch_seq_if.master tw
);
   localparam int               CW        = $clog2(FIFO_DEPTH+1);
   localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(4*ROWS-1);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

   typedef struct packed {
      logic       vld;
      logic [2:0] stage;
      logic [1:0] idx;
   } tag_t;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [2:0]        stage;
      logic [1:0]        idx;
      logic              last;
   } entry_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] cnt;
   tag_t              tag;
   entry_t            push_ent, head_ent;
   logic [CW-1:0]     fifo_count;
   logic [CW:0]       occ;
   logic              xfer, credit_ok, issue, done_nxt;
   logic [DATA_W-1:0] push_data;

   assign xfer      = tw.tw_valid & tw.tw_ready;
   // An in-flight read must always find a free FIFO slot when it lands.
   assign occ       = (CW+1)'(fifo_count) + (CW+1)'(tag.vld);
   assign credit_ok = (occ < (CW+1)'(2)) || xfer;

   always_comb begin
      state_nxt = state;
      issue     = 1'b0;
      done_nxt  = 1'b0;
      case (state)
         IDLE:  if (start && !done) state_nxt = ISSUE;
         ISSUE: begin
            issue = credit_ok;
            if (issue && cnt == ADDR_LAST) state_nxt = DRAIN;
         end
         DRAIN: begin
            if (!tag.vld && (fifo_count == '0 || (fifo_count == CW'(1) && xfer))) begin
               state_nxt = IDLE;
               done_nxt  = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         tag   <= '0;
         done  <= 1'b0;
      end else begin
         state     <= state_nxt;
         done      <= done_nxt;
         tag.vld   <= issue;
         tag.stage <= cnt[4:2];
         tag.idx   <= cnt[1:0];
         if (state == IDLE && state_nxt == ISSUE)
            cnt <= '0;
         else if (issue && cnt != ADDR_LAST)
            cnt <= cnt + ADDR_W'(1);
      end
   end

`ifdef TWIDDLE_CONJ_EN
   // Conjugate for the inverse FFT; the most negative word has no positive twin, so clamp it.
   assign push_data = (rom_data == {1'b1, {(DATA_W-1){1'b0}}}) ? {1'b0, {(DATA_W-1){1'b1}}}
                                                                : (~rom_data + DATA_W'(1));
`else
   assign push_data = rom_data;
`endif

   always_comb begin
      push_ent       = '0;
      push_ent.data  = push_data;
      push_ent.stage = tag.stage;
      push_ent.idx   = tag.idx;
      push_ent.last  = (tag.stage == 3'(ROWS-1)) && (tag.idx == 2'd3);
   end

   twiddle_skid_fifo #(
      .WIDTH($bits(entry_t)),
      .DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (tag.vld),
      .push_dat (push_ent),
      .pop      (xfer),
      .head_dat (head_ent),
      .count    (fifo_count)
   );

   assign rom_addr    = cnt;
   assign busy        = (state != IDLE);
   assign tw.tw_valid = (fifo_count != '0);
   assign tw.tw_data  = head_ent.data;
   assign tw.tw_stage = head_ent.stage;
   assign tw.tw_idx   = head_ent.idx;
   assign tw.tw_last  = head_ent.last;
endmodule

// File: tb/tb_twiddle_fetch_seq.sv
// Directed bench for twiddle_fetch_seq with a registered-read ROM model and a stream capture.
module tb_twiddle_fetch_seq;
   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        busy;
   logic        done;
   logic [4:0]  rom_addr;
   logic [15:0] rom_data;

   twiddle_fetch_seq_if #(.DATA_W(16)) tw_if_i ();

   twiddle_fetch_seq dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .busy     (busy),
      .done     (done),
      .rom_addr (rom_addr),
      .rom_data (rom_data),
      .tw       (tw_if_i)
   );

   always #5 clk = ~clk;

   logic [15:0] rom [0:31];
   always @(posedge clk) rom_data <= rom[rom_addr];

   int n_cmp = 0;
   int n_err = 0;

   logic [15:0] cap_data  [0:63];
   logic [2:0]  cap_stage [0:63];
   logic [1:0]  cap_idx   [0:63];
   logic        cap_last  [0:63];
   int          cap_cyc   [0:63];
   int cap_n, first_valid, done_at, done_cnt, max_cnt, stable_bad, busy_after_done;

   function automatic logic [15:0] exp_word(input logic [15:0] w);
`ifdef TWIDDLE_CONJ_EN
      if (w == 16'h8000) return 16'h7FFF;
      return ~w + 16'd1;
`else
      return w;
`endif
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      start = 1'b0;
      tw_if_i.tw_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // Pulses start, then samples 1ns after every edge; cyc N means "after edge E_N".
   task automatic run_capture(input int pct, input int budget, input int extra_start, input bit start_on_done);
      logic        pv, prdy, pl, r;
      logic [15:0] pd;
      logic [2:0]  ps;
      logic [1:0]  pi;
      cap_n = 0; first_valid = -1; done_at = -1; done_cnt = 0;
      max_cnt = 0; stable_bad = 0; busy_after_done = 0;
      pv = 1'b0; pd = '0; ps = '0; pi = '0; pl = 1'b0;
      start = 1'b1;
      r = (pct >= 100) ? 1'b1 : ($urandom_range(99) < 32'(pct));
      tw_if_i.tw_ready = r;
      prdy = r;
      for (int cyc = 0; cyc < budget; cyc++) begin
         @(posedge clk);
         #1;
         start = (cyc == extra_start);
         if (done_at >= 0 && cyc == done_at + 1 && busy) busy_after_done = 1;
         if (done) begin
            done_cnt++;
            if (done_at < 0) done_at = cyc;
            if (start_on_done) start = 1'b1;
         end
         if (int'(dut.fifo_count) > max_cnt) max_cnt = int'(dut.fifo_count);
         if (pv && !prdy) begin
            if (!tw_if_i.tw_valid || tw_if_i.tw_data !== pd || tw_if_i.tw_stage !== ps ||
                tw_if_i.tw_idx !== pi || tw_if_i.tw_last !== pl) stable_bad++;
         end
         if (tw_if_i.tw_valid && first_valid < 0) first_valid = cyc;
         r = (pct >= 100) ? 1'b1 : ($urandom_range(99) < 32'(pct));
         tw_if_i.tw_ready = r;
         if (tw_if_i.tw_valid && r && cap_n < 64) begin
            cap_data[cap_n]  = tw_if_i.tw_data;
            cap_stage[cap_n] = tw_if_i.tw_stage;
            cap_idx[cap_n]   = tw_if_i.tw_idx;
            cap_last[cap_n]  = tw_if_i.tw_last;
            cap_cyc[cap_n]   = cyc;
            cap_n++;
         end
         pv = tw_if_i.tw_valid; pd = tw_if_i.tw_data; ps = tw_if_i.tw_stage;
         pi = tw_if_i.tw_idx;   pl = tw_if_i.tw_last; prdy = r;
         if (done_at >= 0 && cyc >= done_at + 3) break;
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp += 8;
      if (rom_addr !== 5'd0)               begin n_err++; $display("FAIL reset_rom_addr: got %0d expected 0", rom_addr); end
      if (tw_if_i.tw_valid !== 1'b0)       begin n_err++; $display("FAIL reset_tw_valid: got %b expected 0", tw_if_i.tw_valid); end
      if (tw_if_i.tw_data !== 16'h0000)    begin n_err++; $display("FAIL reset_tw_data: got %h expected 0000", tw_if_i.tw_data); end
      if (tw_if_i.tw_stage !== 3'd0)       begin n_err++; $display("FAIL reset_tw_stage: got %0d expected 0", tw_if_i.tw_stage); end
      if (tw_if_i.tw_idx !== 2'd0)         begin n_err++; $display("FAIL reset_tw_idx: got %0d expected 0", tw_if_i.tw_idx); end
      if (tw_if_i.tw_last !== 1'b0)        begin n_err++; $display("FAIL reset_tw_last: got %b expected 0", tw_if_i.tw_last); end
      if (busy !== 1'b0)                   begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
      if (done !== 1'b0)                   begin n_err++; $display("FAIL reset_done: got %b expected 0", done); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      run_capture(100, 60, -1, 1'b0);
      n_cmp += 4;
      if (first_valid != 2) begin n_err++; $display("FAIL b2b_first_valid: got cycle %0d expected 2", first_valid); end
      if (cap_n != 28)      begin n_err++; $display("FAIL b2b_count: got %0d expected 28", cap_n); end
      if (done_at != 30)    begin n_err++; $display("FAIL b2b_done_cycle: got %0d expected 30", done_at); end
      if (done_cnt != 1)    begin n_err++; $display("FAIL b2b_done_pulses: got %0d expected 1", done_cnt); end
      n_cmp++;
      if (busy !== 1'b0 || busy_after_done != 0) begin n_err++; $display("FAIL b2b_busy_after: got %b/%0d expected 0/0", busy, busy_after_done); end
      for (int i = 0; i < cap_n && i < 28; i++) begin
         n_cmp += 5;
         if (cap_stage[i] !== 3'(i/4)) begin n_err++; $display("FAIL b2b_stage[%0d]: got %0d expected %0d", i, cap_stage[i], i/4); end
         if (cap_idx[i] !== 2'(i%4))   begin n_err++; $display("FAIL b2b_idx[%0d]: got %0d expected %0d", i, cap_idx[i], i%4); end
         if (cap_last[i] !== (i == 27)) begin n_err++; $display("FAIL b2b_last[%0d]: got %b expected %b", i, cap_last[i], i == 27); end
         if (cap_data[i] !== exp_word(rom[i])) begin n_err++; $display("FAIL b2b_data[%0d]: got %h expected %h", i, cap_data[i], exp_word(rom[i])); end
         if (cap_cyc[i] != i + 2)      begin n_err++; $display("FAIL b2b_xfer_cycle[%0d]: got %0d expected %0d", i, cap_cyc[i], i + 2); end
      end
   endtask

   task automatic test_rom_data();
      logic [15:0] e5, e9, e27;
`ifdef TWIDDLE_CONJ_EN
      e5 = 16'h0100; e9 = 16'h00B6; e27 = 16'h0057;
`else
      e5 = 16'hFF00; e9 = 16'hFF4A; e27 = 16'hFFA9;
`endif
      do_reset();
      run_capture(100, 60, -1, 1'b0);
      n_cmp += 3;
      if (cap_data[5] !== e5)   begin n_err++; $display("FAIL data_addr5: got %h expected %h", cap_data[5], e5); end
      if (cap_data[9] !== e9)   begin n_err++; $display("FAIL data_addr9: got %h expected %h", cap_data[9], e9); end
      if (cap_data[27] !== e27) begin n_err++; $display("FAIL data_addr27: got %h expected %h", cap_data[27], e27); end
   endtask

   task automatic test_backpressure();
      do_reset();
      run_capture(30, 3000, -1, 1'b0);
      n_cmp += 4;
      if (cap_n != 28)     begin n_err++; $display("FAIL bp_count: got %0d expected 28", cap_n); end
      if (max_cnt > 2)     begin n_err++; $display("FAIL bp_fifo_max: got %0d expected <=2", max_cnt); end
      if (stable_bad != 0) begin n_err++; $display("FAIL bp_stable: got %0d unstable cycles expected 0", stable_bad); end
      if (done_cnt != 1)   begin n_err++; $display("FAIL bp_done_pulses: got %0d expected 1", done_cnt); end
      for (int i = 0; i < cap_n && i < 28; i++) begin
         n_cmp += 2;
         if (cap_data[i] !== exp_word(rom[i])) begin n_err++; $display("FAIL bp_data[%0d]: got %h expected %h", i, cap_data[i], exp_word(rom[i])); end
         if ({cap_stage[i], cap_idx[i]} !== 5'(i)) begin n_err++; $display("FAIL bp_tag[%0d]: got %0d expected %0d", i, {cap_stage[i], cap_idx[i]}, i); end
      end
   endtask

   task automatic test_reset_mid();
      bit found;
      do_reset();
      found = 1'b0;
      start = 1'b1;
      tw_if_i.tw_ready = 1'b1;
      for (int c = 0; c < 100; c++) begin
         @(posedge clk);
         #1;
         start = 1'b0;
         if (tw_if_i.tw_valid && tw_if_i.tw_stage == 3'd3) begin found = 1'b1; break; end
      end
      n_cmp++;
      if (!found) begin n_err++; $display("FAIL rstmid_reach_row3: got 0 expected 1"); end
      rst = 1'b1;
      @(posedge clk);
      #1;
      n_cmp += 6;
      if (rom_addr !== 5'd0)         begin n_err++; $display("FAIL rstmid_rom_addr: got %0d expected 0", rom_addr); end
      if (tw_if_i.tw_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_tw_valid: got %b expected 0", tw_if_i.tw_valid); end
      if (tw_if_i.tw_data !== 16'h0) begin n_err++; $display("FAIL rstmid_tw_data: got %h expected 0000", tw_if_i.tw_data); end
      if ({tw_if_i.tw_stage, tw_if_i.tw_idx, tw_if_i.tw_last} !== 6'd0) begin n_err++; $display("FAIL rstmid_tags: got %h expected 0", {tw_if_i.tw_stage, tw_if_i.tw_idx, tw_if_i.tw_last}); end
      if (busy !== 1'b0)             begin n_err++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
      if (done !== 1'b0)             begin n_err++; $display("FAIL rstmid_done: got %b expected 0", done); end
      rst = 1'b0;
      run_capture(100, 60, -1, 1'b0);
      n_cmp += 4;
      if (cap_n != 28)   begin n_err++; $display("FAIL rstmid_replay_count: got %0d expected 28", cap_n); end
      if (first_valid != 2) begin n_err++; $display("FAIL rstmid_replay_latency: got %0d expected 2", first_valid); end
      if ({cap_stage[0], cap_idx[0]} !== 5'd0) begin n_err++; $display("FAIL rstmid_replay_first_tag: got %0d expected 0", {cap_stage[0], cap_idx[0]}); end
      if (cap_data[0] !== exp_word(rom[0])) begin n_err++; $display("FAIL rstmid_replay_first_data: got %h expected %h", cap_data[0], exp_word(rom[0])); end
   endtask

   task automatic test_start_busy();
      do_reset();
      run_capture(100, 60, 10, 1'b1);
      n_cmp += 4;
      if (cap_n != 28)          begin n_err++; $display("FAIL sbusy_count: got %0d expected 28", cap_n); end
      if (done_cnt != 1)        begin n_err++; $display("FAIL sbusy_done_pulses: got %0d expected 1", done_cnt); end
      if (busy_after_done != 0) begin n_err++; $display("FAIL sbusy_start_on_done: got busy %0d expected 0", busy_after_done); end
      if (done_at != 30)        begin n_err++; $display("FAIL sbusy_done_cycle: got %0d expected 30", done_at); end
      for (int i = 0; i < cap_n && i < 28; i++) begin
         n_cmp++;
         if ({cap_stage[i], cap_idx[i]} !== 5'(i)) begin n_err++; $display("FAIL sbusy_tag[%0d]: got %0d expected %0d", i, {cap_stage[i], cap_idx[i]}, i); end
      end
   endtask

   task automatic test_saturate();
      logic [15:0] saved, e;
`ifdef TWIDDLE_CONJ_EN
      e = 16'h7FFF;
`else
      e = 16'h8000;
`endif
      saved = rom[3];
      rom[3] = 16'h8000;
      do_reset();
      run_capture(100, 60, -1, 1'b0);
      n_cmp++;
      if (cap_data[3] !== e) begin n_err++; $display("FAIL sat_8000: got %h expected %h", cap_data[3], e); end
      rom[3] = saved;
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      tw_if_i.tw_ready = 1'b0;
      for (int a = 0; a < 32; a++) rom[a] = 16'h0100 + 16'(a) * 16'h0123;
      rom[5]  = 16'hFF00;
      rom[9]  = 16'hFF4A;
      rom[27] = 16'hFFA9;
      test_reset();
      test_back_to_back();
      test_rom_data();
      test_backpressure();
      test_reset_mid();
      test_start_busy();
      test_saturate();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
